// File: rtl/return_stack.sv
// return_stack: LIFO return-address stack with sticky overflow/underflow flags.
// Define RSTACK_WRAP_EN to let a push while full overwrite the oldest entry instead of being dropped.
module return_stack #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clr_err,
  input  logic [WIDTH-1:0]      d,
  output logic [WIDTH-1:0]      q,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  ovf,
  output logic                  unf
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] SP_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2+1)'(1);
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] sp_q, sp_d, top_addr, wr_addr;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d, wr_en;
  assign top_addr = sp_q - SP_ONE;
  assign count    = count_q;
  assign full     = count_q == (DEPTH_LOG2+1)'(DEPTH);
  assign empty    = count_q == '0;
  assign q        = empty ? '0 : mem_q[top_addr];
  assign ovf      = ovf_q;
  assign unf      = unf_q;
  always_comb begin
    sp_d    = sp_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_addr = sp_q;
    ovf_d   = (ovf_q & ~clr_err) | (push & ~pop & full);
    unf_d   = (unf_q & ~clr_err) | (pop & ~push & empty);
    // a simultaneous push/pop on an empty stack degenerates to a plain push
    if (push && (!pop || empty)) begin
      if (!full) begin
        wr_en   = 1'b1;
        sp_d    = sp_q + SP_ONE;
        count_d = count_q + CNT_ONE;
      end
`ifdef RSTACK_WRAP_EN
      else begin
        wr_en = 1'b1;
        sp_d  = sp_q + SP_ONE;
      end
`endif
    end else if (push && pop) begin
      wr_en   = 1'b1;
      wr_addr = top_addr;
    end else if (pop && !empty) begin
      sp_d    = top_addr;
      count_d = count_q - CNT_ONE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_addr] <= d;
  end
endmodule

// File: tb/tb_return_stack.sv
// tb_return_stack: directed-vector bench for return_stack with hand-computed expectations.
module tb_return_stack;
  logic        clk = 1'b0;
  logic        rst, push, pop, clr_err;
  logic [31:0] d, q;
  logic [3:0]  count;
  logic        full, empty, ovf, unf;
  int          vectors = 0;
  int          miscompares = 0;
  return_stack dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .clr_err(clr_err),
    .d(d), .q(q), .count(count), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic p, input logic o, input logic [31:0] v, input logic c, input logic r);
    push = p; pop = o; d = v; clr_err = c; rst = r;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0; rst = 1'b0;
  endtask
  initial begin
    push = 1'b0; pop = 1'b0; clr_err = 1'b0; rst = 1'b0; d = '0;
    #1;
    cyc(0, 0, 0, 0, 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_q", q, 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_unf", 32'(unf), 0);
    cyc(1, 0, 32'h11, 0, 0);
    chk("push1_q", q, 32'h11);
    cyc(1, 0, 32'h22, 0, 0);
    cyc(1, 0, 32'h33, 0, 0);
    chk("push3_count", 32'(count), 3);
    chk("push3_q", q, 32'h33);
    cyc(0, 0, 32'hDEAD, 0, 0);
    chk("hold_q", q, 32'h33);
    chk("hold_count", 32'(count), 3);
    for (int i = 0; i < 3; i++) begin
      chk("lifo_pop_q", q, 32'h33 - 32'(i) * 32'h11);
      cyc(0, 1, 0, 0, 0);
    end
    chk("pop_empty", 32'(empty), 1);
    chk("pop_q0", q, 0);
    cyc(0, 1, 0, 0, 0);
    chk("unf_set", 32'(unf), 1);
    chk("unf_count", 32'(count), 0);
    chk("unf_q", q, 0);
    cyc(0, 1, 0, 1, 0);
    chk("unf_set_wins", 32'(unf), 1);
    cyc(0, 0, 0, 1, 0);
    chk("unf_clr", 32'(unf), 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 32'h100 + 32'(i), 0, 0);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 8);
    chk("fill_q", q, 32'h107);
    chk("fill_not_empty", 32'(empty), 0);
    cyc(1, 0, 32'h1FF, 0, 0);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_count", 32'(count), 8);
    chk("ovf_full", 32'(full), 1);
`ifdef RSTACK_WRAP_EN
    chk("ovf_q", q, 32'h1FF);
    for (int i = 0; i < 8; i++) begin
      chk("wrap_pop_q", q, i == 0 ? 32'h1FF : 32'h108 - 32'(i));
      cyc(0, 1, 0, 0, 0);
    end
`else
    chk("ovf_q", q, 32'h107);
    for (int i = 0; i < 8; i++) begin
      chk("drop_pop_q", q, 32'h107 - 32'(i));
      cyc(0, 1, 0, 0, 0);
    end
`endif
    chk("drain_empty", 32'(empty), 1);
    chk("ovf_sticky", 32'(ovf), 1);
    cyc(0, 0, 0, 1, 0);
    chk("ovf_clr", 32'(ovf), 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 32'h200 + 32'(i), 0, 0);
    cyc(1, 1, 32'h2EE, 0, 0);
    chk("full_repl_q", q, 32'h2EE);
    chk("full_repl_count", 32'(count), 8);
    chk("full_repl_ovf", 32'(ovf), 0);
    cyc(0, 1, 0, 0, 0);
    chk("full_repl_below", q, 32'h206);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 32'hA, 0, 0);
    cyc(1, 0, 32'hB, 0, 0);
    cyc(1, 1, 32'hC, 0, 0);
    chk("repl_count", 32'(count), 2);
    chk("repl_q", q, 32'hC);
    cyc(0, 1, 0, 0, 0);
    chk("repl_pop_q", q, 32'hA);
    cyc(0, 1, 0, 0, 0);
    chk("repl_empty", 32'(empty), 1);
    cyc(1, 1, 32'hC, 0, 0);
    chk("pp_empty_count", 32'(count), 1);
    chk("pp_empty_q", q, 32'hC);
    chk("pp_empty_unf", 32'(unf), 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 32'h5, 0, 0);
    cyc(1, 0, 32'h6, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 32'h5, 0, 0);
    cyc(1, 0, 32'h6, 0, 0);
    chk("pre_rst_unf", 32'(unf), 1);
    cyc(1, 0, 32'h7, 0, 1);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_ovf", 32'(ovf), 0);
    chk("mid_rst_unf", 32'(unf), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_q", q, 0);
    cyc(1, 0, 32'h9, 0, 0);
    chk("post_rst_q", q, 32'h9);
    chk("post_rst_count", 32'(count), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
